// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU / multiply-divide unit:
// function codes and the sequencing state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_NOR   = 4'd4;
    localparam logic [3:0] ALU_SLTU  = 4'd5;
    localparam logic [3:0] ALU_LUI   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SLL   = 4'd8;
    localparam logic [3:0] ALU_SRL   = 4'd9;
    localparam logic [3:0] ALU_SRA   = 4'd10;
    localparam logic [3:0] ALU_XOR   = 4'd11;
    localparam logic [3:0] ALU_MULTU = 4'd12;
    localparam logic [3:0] ALU_DIVU  = 4'd13;
    localparam logic [3:0] ALU_MFHI  = 4'd14;
    localparam logic [3:0] ALU_MFLO  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle; res_*_o present the values the registers take after the current step.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // acc holds the product high half / partial remainder; mq holds the
    // multiplier being consumed / dividend being turned into the quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        acc_d     = acc_q;
        mq_d      = mq_q;
        if (div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_d = div_diff[WIDTH-1:0];
                mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = div_shift[WIDTH-1:0];
                mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = mul_sum[WIDTH:1];
            mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            div_q  <= 1'b0;
            acc_q  <= '0;
            mq_q   <= '0;
            opnd_q <= '0;
        end else if (load_i) begin
            cnt_q  <= CW'(WIDTH - 1);
            div_q  <= div_i;
            acc_q  <= '0;
            mq_q   <= div_i ? a_i : b_i;
            opnd_q <= div_i ? b_i : a_i;
        end else if (step_i) begin
            cnt_q <= cnt_q - 1'b1;
            acc_q <= acc_d;
            mq_q  <= mq_d;
        end
    end

    assign last_o   = (cnt_q == '0);
    assign res_hi_o = acc_d;
    assign res_lo_o = mq_d;

endmodule

// File: rtl/alu_mdu.sv
// Registered execute-stage ALU with iterative MULTU/DIVU into HI/LO behind a
// start/busy/done handshake.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zero_flag_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] out_q, hi_q, lo_q;
    logic             zero_q, busy_q, done_q;

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic             is_mul, is_div, div_by_zero;
    logic             load_md;
    logic             md_last;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign sh          = a_i[SHW-1:0];
    assign is_mul      = (func_i == ALU_MULTU);
    assign div_by_zero = (b_i == '0);
    assign is_div      = (func_i == ALU_DIVU) && !div_by_zero;
    assign load_md     = start_i && (state_q == IDLE) && (is_mul || is_div);

    always_comb begin
        alu_res = '0;
        case (func_i)
            ALU_ADD:   alu_res = a_i + b_i;
            ALU_SUB:   alu_res = a_i - b_i;
            ALU_AND:   alu_res = a_i & b_i;
            ALU_OR:    alu_res = a_i | b_i;
            ALU_NOR:   alu_res = ~(a_i | b_i);
            ALU_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_LUI:   alu_res = b_i << (WIDTH / 2);
            ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLL:   alu_res = b_i << sh;
            ALU_SRL:   alu_res = b_i >> sh;
            ALU_SRA:   alu_res = $unsigned($signed(b_i) >>> sh);
            ALU_XOR:   alu_res = a_i ^ b_i;
            ALU_DIVU:  alu_res = '1;
            ALU_MFHI:  alu_res = hi_q;
            ALU_MFLO:  alu_res = lo_q;
            default:   alu_res = '0;
        endcase
    end

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load_md),
        .div_i    (is_div),
        .step_i   (busy_q),
        .a_i      (a_i),
        .b_i      (b_i),
        .last_o   (md_last),
        .res_hi_o (md_hi),
        .res_lo_o (md_lo)
    );

    // Starts arriving outside IDLE are dropped; only IDLE looks at start_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            out_q   <= '0;
            zero_q  <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (is_mul) begin
                            state_q <= MUL;
                            busy_q  <= 1'b1;
                        end else if (is_div) begin
                            state_q <= DIV;
                            busy_q  <= 1'b1;
                        end else begin
                            out_q  <= alu_res;
                            zero_q <= (alu_res == '0);
                            done_q <= 1'b1;
                            if (func_i == ALU_DIVU) begin
                                hi_q <= a_i;
                                lo_q <= '1;
                            end
                        end
                    end
                end
                MUL, DIV: begin
                    if (md_last) begin
                        hi_q    <= md_hi;
                        lo_q    <= md_lo;
                        out_q   <= md_lo;
                        zero_q  <= (md_lo == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_o       = out_q;
    assign zero_flag_o = zero_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected results are queued at issue time and
// compared against each done pulse, including the cycle it arrives in.
module tb_alu_mdu;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [3:0]   func_i;
    logic [W-1:0] a_i, b_i;
    logic [W-1:0] out_o, hi_o, lo_o;
    logic         zero_flag_o, busy_o, done_o;

    exp_t         sb[$];
    exp_t         mon_e;
    int           cyc    = 0;
    int           n_vec  = 0;
    int           n_err  = 0;
    int           n_push = 0;
    int           n_done = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .func_i      (func_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_o       (out_o),
        .zero_flag_o (zero_flag_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk_i) begin
        cyc++;
        #1;
        if (done_o) begin
            n_done++;
            check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_val("out",  64'(out_o), 64'(mon_e.out));
                check_val("zero", 64'(zero_flag_o), 64'(mon_e.out == '0));
                check_val("hi",   64'(hi_o), 64'(mon_e.hi));
                check_val("lo",   64'(lo_o), 64'(mon_e.lo));
                check_val("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic [W-1:0] nhi, output logic [W-1:0] nlo);
        logic [63:0] p;
        logic [4:0]  s;
        s   = a[4:0];
        nhi = m_hi;
        nlo = m_lo;
        res = '0;
        case (f)
            4'd0:  res = a + b;
            4'd1:  res = a - b;
            4'd2:  res = a & b;
            4'd3:  res = a | b;
            4'd4:  res = ~(a | b);
            4'd5:  res = (a < b) ? 32'd1 : 32'd0;
            4'd6:  res = {b[15:0], 16'h0000};
            4'd7:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  res = b << s;
            4'd9:  res = b >> s;
            4'd10: res = $unsigned($signed(b) >>> s);
            4'd11: res = a ^ b;
            4'd12: begin
                p   = {32'h0, a} * {32'h0, b};
                nhi = p[63:32];
                nlo = p[31:0];
                res = nlo;
            end
            4'd13: begin
                if (b == 0) begin
                    nhi = a;
                    nlo = '1;
                end else begin
                    nhi = a % b;
                    nlo = a / b;
                end
                res = nlo;
            end
            4'd14: res = m_hi;
            default: res = m_lo;
        endcase
    endtask

    // Drives start for one cycle beginning at the next negedge; caller deasserts.
    task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        logic [W-1:0] res, nhi, nlo;
        bit           multi;
        model(f, a, b, res, nhi, nlo);
        multi = (f == 4'd12) || (f == 4'd13 && b != 0);
        @(negedge clk_i);
        start_i = 1'b1;
        func_i  = f;
        a_i     = a;
        b_i     = b;
        if (push) begin
            sb.push_back('{res, nhi, nlo, cyc + 1 + (multi ? W : 0)});
            n_push++;
            m_hi = nhi;
            m_lo = nlo;
        end
    endtask

    task automatic idle();
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check_val("idle_timeout", 64'(busy_o), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_out"},  64'(out_o), 64'd0);
        check_val({tag, "_zero"}, 64'(zero_flag_o), 64'd1);
        check_val({tag, "_hi"},   64'(hi_o), 64'd0);
        check_val({tag, "_lo"},   64'(lo_o), 64'd0);
        check_val({tag, "_busy"}, 64'(busy_o), 64'd0);
        check_val({tag, "_done"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0]   f;
        logic [W-1:0] ra, rb;
        rst_i   = 1'b1;
        start_i = 1'b0;
        func_i  = '0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(negedge clk_i);
        check_reset_state("por");
        rst_i = 1'b0;

        // Back-to-back single-cycle ops.
        issue(4'd0,  32'h7FFF_FFFF, 32'h1, 1);
        issue(4'd1,  32'd5, 32'd5, 1);
        issue(4'd7,  32'hFFFF_FFFF, 32'h1, 1);
        issue(4'd5,  32'hFFFF_FFFF, 32'h1, 1);
        issue(4'd10, 32'd4, 32'h8000_0000, 1);
        issue(4'd8,  32'd33, 32'd1, 1);
        issue(4'd9,  32'd31, 32'h8000_0000, 1);
        issue(4'd11, 32'hF0F0_1234, 32'h0FF0_4321, 1);
        issue(4'd4,  32'h0, 32'h0, 1);
        issue(4'd2,  32'hFF00_FF00, 32'h0F0F_0F0F, 1);
        issue(4'd3,  32'h1200_0000, 32'h0000_0034, 1);
        issue(4'd6,  32'h0, 32'h0000_ABCD, 1);
        idle();

        // MULTU with busy duration, then read back HI/LO.
        issue(4'd12, 32'hFFFF_FFFF, 32'd2, 1);
        idle();
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        check_val("mul_busy_cycles", 64'(n), 64'd32);
        issue(4'd14, 32'h0, 32'h0, 1);
        issue(4'd15, 32'h0, 32'h0, 1);
        idle();

        issue(4'd13, 32'd100, 32'd7, 1);
        idle();
        wait_idle();

        // Divide by zero completes in one cycle without raising busy.
        issue(4'd13, 32'd9, 32'd0, 1);
        idle();
        check_val("div0_busy", 64'(busy_o), 64'd0);

        // A start during MULTU must be dropped.
        issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        idle();
        repeat (4) @(negedge clk_i);
        start_i = 1'b1;
        func_i  = 4'd0;
        a_i     = 32'd1;
        b_i     = 32'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_idle();
        issue(4'd14, 32'h0, 32'h0, 1);
        idle();

        // Reset in the middle of a DIVU aborts it.
        issue(4'd13, 32'd100, 32'd7, 0);
        idle();
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        check_reset_state("midrst");
        issue(4'd0, 32'd2, 32'd3, 1);
        issue(4'd15, 32'h0, 32'h0, 1);
        idle();

        for (int i = 0; i < 40; i++) begin
            f  = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (f == 4'd13 && $urandom_range(0, 3) == 0) rb = '0;
            issue(f, ra, rb, 1);
            if (f == 4'd12 || (f == 4'd13 && rb != 0)) begin
                idle();
                wait_idle();
            end
        end
        idle();

        repeat (5) @(negedge clk_i);
        check_val("done_count", 64'(n_done), 64'(n_push));
        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, registered successor to the combinational CPU ALU. It adds signed compare, shifts and XOR, plus iterative unsigned multiply/divide into HI/LO registers behind a start/busy/done handshake. It sits in the execute stage of the multi-cycle MIPS datapath; the controller stalls on `busy` and samples `out` when `done` is high.

## Interface
- `WIDTH`, 32: operand/result width; even, ≥ 8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch operation; accepted only while `busy`=0.
- `func`  in  4  operation code, sampled with `start`.
- `a`, `b`  in  WIDTH  operands, sampled with `start`.
- `out`  out  WIDTH  registered result.
- `zero_flag`  out  1  registered, equals (`out`==0).
- `hi`, `lo`  out  WIDTH  HI/LO registers.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse when `out` is updated.

## Operation
- Function codes:
  - 0 ADD a+b; 1 SUB a−b; 2 AND; 3 OR; 4 NOR; 5 SLTU (unsigned a<b); 6 LUI b<<(WIDTH/2); 7 SLT (signed).
  - 8 SLL b<<sh; 9 SRL; 10 SRA; 11 XOR; 12 MULTU; 13 DIVU; 14 MFHI (out=hi); 15 MFLO (out=lo).
  - sh = a[$clog2(WIDTH)-1:0]; upper bits of a are ignored.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag. SLT/SLTU produce 0 or 1, zero-extended.
- MULTU: {hi,lo} = a×b, 2·WIDTH-bit unsigned, shift-add, one bit per cycle.
- DIVU: lo = a/b, hi = a%b, restoring division, one quotient bit per cycle.
- DIVU with b=0 takes the fast path: lo = all ones, hi = a, completes like a single-cycle op.
- For MULTU/DIVU, `out` receives the new lo value.
- FSM:
  - IDLE: on start with func 12 (b≠0 for 13) → MUL/DIV, load counter = WIDTH−1. Otherwise complete in one cycle and stay in IDLE.
  - MUL/DIV: one iteration per cycle. When counter=0, write hi/lo/out, pulse done, return to IDLE.
- `start` while busy=1 is ignored: no queueing, no effect on the running op.
- hi/lo change only on MULTU/DIVU completion or reset.
- Reset (any cycle, including mid-operation) aborts the running op. All outputs reset: out=0, zero_flag=1, hi=0, lo=0, busy=0, done=0, state=IDLE.

## Timing
- start sampled at edge ending cycle T.
- Single-cycle ops, including DIVU by zero:
  - out, zero_flag and done=1 visible in cycle T+1.
  - busy stays 0, so back-to-back starts every cycle are legal.
- MULTU/DIVU:
  - busy=1 in cycles T+1 … T+WIDTH.
  - In cycle T+WIDTH+1: busy=0, done=1, out/hi/lo/zero_flag updated.
  - A new start is accepted in cycle T+WIDTH+1.
- done is high for exactly one cycle per accepted op. out holds its value until the next completion.
- rst asserted in cycle R: all outputs at reset values in R+1; start in R+1 is accepted normally.

## Structure
- Package `alu_pkg`: func code constants (ALU_ADD … ALU_MFLO) and FSM state typedef (IDLE, MUL, DIV).
- Sub-module `alu_muldiv`: iterative multiply/divide datapath with counter, accumulator and remainder registers. The top level holds the combinational ops, output registers and handshake.

## Test plan
- ADD 0x7FFFFFFF+1 → out 0x80000000, zero_flag 0, done at T+1. SUB 5−5 → out 0, zero_flag 1.
- a=0xFFFFFFFF, b=1: SLT → 1, SLTU → 0. SRA b=0x80000000, a=4 → 0xF8000000. SLL a=33, b=1 → 2 (sh=1).
- MULTU 0xFFFFFFFF×2 → hi 1, lo 0xFFFFFFFE, out 0xFFFFFFFE. busy exactly 32 cycles, done at T+33; then MFHI → out 1.
- DIVU 100/7 → lo 14, hi 2 at T+33. DIVU 9/0 → lo 0xFFFFFFFF, hi 9, done at T+1, busy never high.
- During MULTU, pulse start with ADD at T+5 → ignored: no extra done, MULTU result unchanged.
- rst at T+10 of DIVU → next cycle busy 0, hi/lo/out 0, zero_flag 1. A following ADD 2+3 → 5 at +1.
